// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode scanner with blanking gaps between digits and a
// double-buffered result/operation latch that only changes on frame boundaries.
module seven_seg_scanner #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       load,
   input  logic [7:0] y_in,
   input  logic [3:0] op_in,
   output logic [3:0] an,
   output logic [7:0] y_out,
   output logic [3:0] op_out,
   output logic [1:0] digit_idx,
   output logic       frame_tick
);

   localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       digit_q;
   logic [3:0]       an_q;
   logic             tick_q;
   logic [7:0]       shadow_y_q, shadow_y_d, y_q, y_d;
   logic [3:0]       shadow_op_q, shadow_op_d, op_q, op_d;
   logic             pending_q, pending_d;
   logic             blank_end_s, show_end_s, boundary_s, xfer_s;

   function automatic logic [3:0] anode_map(input logic [1:0] idx);
      case (idx)
         2'd0:    anode_map = 4'b1110;
         2'd1:    anode_map = 4'b1101;
         2'd2:    anode_map = 4'b1011;
         2'd3:    anode_map = 4'b0111;
         default: anode_map = 4'b1111;
      endcase
   endfunction

   assign blank_end_s = (cnt_q == BLANK_LAST);
   assign show_end_s  = (cnt_q == SHOW_LAST);
   assign boundary_s  = enable && (state_q == ST_SHOW) && show_end_s && (digit_q == 2'd3);
   // While disabled the display is dark, so pending data may move to the outputs at once.
   assign xfer_s      = !enable || boundary_s;

   always_comb begin
      shadow_y_d  = shadow_y_q;
      shadow_op_d = shadow_op_q;
      pending_d   = pending_q;
      y_d         = y_q;
      op_d        = op_q;
      if (load) begin
         shadow_y_d  = y_in;
         shadow_op_d = op_in;
      end else begin
         shadow_y_d  = shadow_y_q;
         shadow_op_d = shadow_op_q;
      end
      if (xfer_s) begin
         pending_d = 1'b0;
         if (load) begin
            y_d  = y_in;
            op_d = op_in;
         end else if (pending_q) begin
            y_d  = shadow_y_q;
            op_d = shadow_op_q;
         end else begin
            y_d  = y_q;
            op_d = op_q;
         end
      end else if (load) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         digit_q <= 2'd0;
         an_q    <= 4'b1111;
         tick_q  <= 1'b0;
      end else if (!enable) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         digit_q <= 2'd0;
         an_q    <= 4'b1111;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         case (state_q)
            ST_BLANK: begin
               if (blank_end_s) begin
                  state_q <= ST_SHOW;
                  cnt_q   <= '0;
                  an_q    <= anode_map(digit_q);
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_SHOW: begin
               if (show_end_s) begin
                  state_q <= ST_BLANK;
                  cnt_q   <= '0;
                  digit_q <= digit_q + 2'd1;
                  an_q    <= 4'b1111;
                  tick_q  <= (digit_q == 2'd3);
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_BLANK;
               cnt_q   <= '0;
               digit_q <= 2'd0;
               an_q    <= 4'b1111;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_y_q  <= 8'h00;
         shadow_op_q <= 4'h0;
         pending_q   <= 1'b0;
         y_q         <= 8'h00;
         op_q        <= 4'h0;
      end else begin
         shadow_y_q  <= shadow_y_d;
         shadow_op_q <= shadow_op_d;
         pending_q   <= pending_d;
         y_q         <= y_d;
         op_q        <= op_d;
      end
   end

   assign an         = an_q;
   assign y_out      = y_q;
   assign op_out     = op_q;
   assign digit_idx  = digit_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed vector table, hand-written
// enable/reset sequences, and randomized traffic against a frame-position model.
module tb_seven_seg_scanner;

   localparam int RD    = 4;
   localparam int BC    = 2;
   localparam int SLOT  = RD + BC;
   localparam int FRAME = 4 * SLOT;

   logic       clk = 1'b0;
   logic       rst_n, enable, load;
   logic [7:0] y_in;
   logic [3:0] op_in;
   logic [3:0] an;
   logic [7:0] y_out;
   logic [3:0] op_out;
   logic [1:0] digit_idx;
   logic       frame_tick;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: scan position since last restart plus latch contents.
   int         m_pos;
   logic       m_pend;
   logic [7:0] m_sy, m_y;
   logic [3:0] m_sop, m_op;

   seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
      .y_in(y_in), .op_in(op_in), .an(an), .y_out(y_out), .op_out(op_out),
      .digit_idx(digit_idx), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       ld;
      logic [7:0] y;
      logic [3:0] op;
      logic [3:0] e_an;
      logic [1:0] e_dig;
      logic       e_tick;
      logic [7:0] e_y;
      logic [3:0] e_op;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_an(input int pos);
      int d, r;
      d = (pos % FRAME) / SLOT;
      r = pos % SLOT;
      if (r < BC) return 4'b1111;
      return ~(4'b0001 << d);
   endfunction

   function automatic logic [1:0] exp_dig(input int pos);
      return 2'((pos % FRAME) / SLOT);
   endfunction

   function automatic logic exp_tick(input int pos);
      return (pos != 0) && (pos % FRAME == 0);
   endfunction

   task automatic model_reset();
      m_pos = 0; m_pend = 1'b0; m_sy = 8'h00; m_y = 8'h00; m_sop = 4'h0; m_op = 4'h0;
   endtask

   task automatic model_step(input logic en, input logic ld, input logic [7:0] y, input logic [3:0] op);
      int  np;
      logic bnd;
      np  = en ? m_pos + 1 : 0;
      bnd = en && (np % FRAME == 0);
      if (!en || bnd) begin
         if (ld) begin
            m_y = y; m_op = op;
         end else if (m_pend) begin
            m_y = m_sy; m_op = m_sop;
         end
         m_pend = 1'b0;
      end else if (ld) begin
         m_pend = 1'b1;
      end
      if (ld) begin
         m_sy = y; m_sop = op;
      end
      m_pos = np;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b1; load = 1'b0; y_in = 8'h00; op_in = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic step(input logic en, input logic ld, input logic [7:0] y, input logic [3:0] op);
      enable = en; load = ld; y_in = y; op_in = op;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int k;
      logic en_r, ld_r;
      logic [7:0] y_r;
      logic [3:0] op_r;

      // cyc, ld, y, op, an, dig, tick, y_out, op_out (values visible in cycle cyc)
      tbl.push_back('{ 0, 1'b0, 8'h00, 4'h0, 4'hF, 2'd0, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{ 1, 1'b0, 8'h00, 4'h0, 4'hF, 2'd0, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{ 2, 1'b0, 8'h00, 4'h0, 4'hE, 2'd0, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{ 5, 1'b1, 8'hA5, 4'h3, 4'hE, 2'd0, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{ 6, 1'b0, 8'h00, 4'h0, 4'hF, 2'd1, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{ 8, 1'b0, 8'h00, 4'h0, 4'hD, 2'd1, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{11, 1'b0, 8'h00, 4'h0, 4'hD, 2'd1, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{14, 1'b0, 8'h00, 4'h0, 4'hB, 2'd2, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{17, 1'b0, 8'h00, 4'h0, 4'hB, 2'd2, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{20, 1'b0, 8'h00, 4'h0, 4'h7, 2'd3, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{23, 1'b0, 8'h00, 4'h0, 4'h7, 2'd3, 1'b0, 8'h00, 4'h0});
      tbl.push_back('{24, 1'b0, 8'h00, 4'h0, 4'hF, 2'd0, 1'b1, 8'hA5, 4'h3});
      tbl.push_back('{25, 1'b0, 8'h00, 4'h0, 4'hF, 2'd0, 1'b0, 8'hA5, 4'h3});
      tbl.push_back('{26, 1'b0, 8'h00, 4'h0, 4'hE, 2'd0, 1'b0, 8'hA5, 4'h3});
      tbl.push_back('{27, 1'b1, 8'h11, 4'h1, 4'hE, 2'd0, 1'b0, 8'hA5, 4'h3});
      tbl.push_back('{39, 1'b1, 8'h7E, 4'h2, 4'hB, 2'd2, 1'b0, 8'hA5, 4'h3});
      tbl.push_back('{47, 1'b0, 8'h00, 4'h0, 4'h7, 2'd3, 1'b0, 8'hA5, 4'h3});
      tbl.push_back('{48, 1'b0, 8'h00, 4'h0, 4'hF, 2'd0, 1'b1, 8'h7E, 4'h2});
      tbl.push_back('{71, 1'b1, 8'hC4, 4'h9, 4'h7, 2'd3, 1'b0, 8'h7E, 4'h2});
      tbl.push_back('{72, 1'b0, 8'h00, 4'h0, 4'hF, 2'd0, 1'b1, 8'hC4, 4'h9});
      tbl.push_back('{96, 1'b0, 8'h00, 4'h0, 4'hF, 2'd0, 1'b1, 8'hC4, 4'h9});

      // Directed table: scan order, deferred load, last-load-wins, boundary bypass.
      do_reset();
      for (int c = 0; c <= 97; c++) begin
         k = -1;
         foreach (tbl[i]) if (tbl[i].cyc == c) k = i;
         enable = 1'b1;
         load   = 1'b0;
         y_in   = 8'($urandom);
         op_in  = 4'($urandom);
         if (k >= 0) begin
            load = tbl[k].ld;
            if (tbl[k].ld) begin
               y_in  = tbl[k].y;
               op_in = tbl[k].op;
            end
            chk($sformatf("tbl%0d_an", c),   32'(an),         32'(tbl[k].e_an));
            chk($sformatf("tbl%0d_dig", c),  32'(digit_idx),  32'(tbl[k].e_dig));
            chk($sformatf("tbl%0d_tick", c), 32'(frame_tick), 32'(tbl[k].e_tick));
            chk($sformatf("tbl%0d_y", c),    32'(y_out),      32'(tbl[k].e_y));
            chk($sformatf("tbl%0d_op", c),   32'(op_out),     32'(tbl[k].e_op));
         end
         @(posedge clk);
         @(negedge clk);
      end

      // Enable drop mid-scan, load while disabled, restart.
      do_reset();
      repeat (10) step(1'b1, 1'b0, 8'h00, 4'h0);
      chk("en_pre_an", 32'(an), 32'(4'hD));
      step(1'b0, 1'b0, 8'h00, 4'h0);
      chk("en_off_an", 32'(an), 32'(4'hF));
      chk("en_off_dig", 32'(digit_idx), 32'(2'd0));
      chk("en_off_tick", 32'(frame_tick), 32'(1'b0));
      step(1'b0, 1'b0, 8'h00, 4'h0);
      step(1'b0, 1'b1, 8'h5A, 4'h6);
      chk("en_off_y", 32'(y_out), 32'(8'h5A));
      chk("en_off_op", 32'(op_out), 32'(4'h6));
      step(1'b0, 1'b0, 8'h00, 4'h0);
      step(1'b1, 1'b0, 8'h00, 4'h0);
      chk("en_on1_an", 32'(an), 32'(4'hF));
      step(1'b1, 1'b0, 8'h00, 4'h0);
      chk("en_on2_an", 32'(an), 32'(4'hE));
      chk("en_on2_dig", 32'(digit_idx), 32'(2'd0));
      chk("en_on2_tick", 32'(frame_tick), 32'(1'b0));
      step(1'b1, 1'b0, 8'h00, 4'h0);
      chk("ar_pre_an", 32'(an), 32'(4'hE));

      // Asynchronous reset between clock edges during SHOW.
      #2 rst_n = 1'b0;
      #1;
      chk("ar_an", 32'(an), 32'(4'hF));
      chk("ar_y", 32'(y_out), 32'(8'h00));
      chk("ar_op", 32'(op_out), 32'(4'h0));
      chk("ar_dig", 32'(digit_idx), 32'(2'd0));
      chk("ar_tick", 32'(frame_tick), 32'(1'b0));

      // Randomized traffic against the model.
      do_reset();
      chk("rnd_rst_an", 32'(an), 32'(4'hF));
      chk("rnd_rst_y", 32'(y_out), 32'(8'h00));
      for (int i = 0; i < 2000; i++) begin
         en_r = ($urandom_range(0, 15) != 0);
         ld_r = ($urandom_range(0, 7) == 0);
         y_r  = 8'($urandom);
         op_r = 4'($urandom);
         enable = en_r; load = ld_r; y_in = y_r; op_in = op_r;
         @(posedge clk);
         model_step(en_r, ld_r, y_r, op_r);
         @(negedge clk);
         chk($sformatf("rnd%0d_an", i),   32'(an),         32'(exp_an(m_pos)));
         chk($sformatf("rnd%0d_dig", i),  32'(digit_idx),  32'(exp_dig(m_pos)));
         chk($sformatf("rnd%0d_tick", i), 32'(frame_tick), 32'(exp_tick(m_pos)));
         chk($sformatf("rnd%0d_y", i),    32'(y_out),      32'(m_y));
         chk($sformatf("rnd%0d_op", i),   32'(op_out),     32'(m_op));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
